sqrt_seq: RTL and testbench



---
 rtl/sqrt_seq.sv | 174 +++++++++++++++++
 tb/tb_sqrt_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_seq.sv
// ---------------------------------------------------------------------------
// sqrt_seq
// Sequential integer square root. One root bit is resolved per clock using
// the restoring digit-by-digit method. It takes N = (width+1)/2 cycles from
// the accepting edge to a single-cycle done pulse.
//
// Optional feature macro: SQRT_SEQ_REM_EN
//   defined   -> remainder output is registered and driven
//   undefined -> remainder output is tied to zero (root is unaffected)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only while idle
//   a          in   radicand (width bits)
//   tc         in   1 = a is two's complement
//   busy       out  computation in progress
//   done       out  one-cycle completion pulse
//   root       out  floor(sqrt(|a|)), N bits
//   remainder  out  |a| - root^2, N+1 bits
//   neg        out  radicand was negative (magnitude was used)
// ---------------------------------------------------------------------------
module sqrt_seq #(
  parameter int width = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [width-1:0]        a,
  input  logic                    tc,
  output logic                    busy,
  output logic                    done,
  output logic [(width+1)/2-1:0]  root,
  output logic [(width+1)/2:0]    remainder,
  output logic                    neg
);

  localparam int N  = (width + 1) / 2;
  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE,
    CALC
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   rad_q, rad_d;
  logic [N+1:0]     prem_q, prem_d;
  logic [N-1:0]     proot_q, proot_d;
  logic             negAcc_q, negAcc_d;
  logic [N-1:0]     root_q, root_d;
  logic             neg_q, neg_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
`ifdef SQRT_SEQ_REM_EN
  logic [N:0]       rem_q, rem_d;
`endif

  logic [width-1:0] mag;
  logic [N+3:0]     minuend;
  logic [N+3:0]     trial;
  logic [N:0]       rootShift;
  logic             trialNeg;
  logic             unusedBits;

  // Magnitude of the radicand. The most negative value maps onto
  // 2^(width-1), which still fits as a width-bit unsigned number.
  assign mag = (tc && a[width-1]) ? ((~a) + width'(1)) : a;

  // The trial subtraction is carried out with two spare bits so its sign
  // can be read directly. A non-negative trial means the next root bit is 1.
  assign minuend   = {prem_q, rad_q[2*N-1 -: 2]};
  assign trial     = minuend - {2'b00, proot_q, 2'b01};
  assign trialNeg  = trial[N+3];
  assign rootShift = {proot_q, ~trialNeg};

  // trial[N+2] is guaranteed zero for a valid trial, and the root's top
  // bit only leaves the register once the last iteration is done.
  assign unusedBits = ^{trial[N+2], rootShift[N]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rad_d    = rad_q;
    prem_d   = prem_q;
    proot_d  = proot_q;
    negAcc_d = negAcc_q;
    root_d   = root_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
`ifdef SQRT_SEQ_REM_EN
    rem_d    = rem_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          rad_d            = '0;
          rad_d[width-1:0] = mag;
          prem_d           = '0;
          proot_d          = '0;
          negAcc_d         = tc & a[width-1];
          cnt_d            = CW'(N);
          busy_d           = 1'b1;
          state_d          = CALC;
        end
      end

      CALC: begin
        prem_d  = trialNeg ? minuend[N+1:0] : trial[N+1:0];
        proot_d = rootShift[N-1:0];
        rad_d   = rad_q << 2;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          root_d  = rootShift[N-1:0];
          neg_d   = negAcc_q;
`ifdef SQRT_SEQ_REM_EN
          rem_d   = prem_d[N:0];
`endif
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rad_q    <= '0;
      prem_q   <= '0;
      proot_q  <= '0;
      negAcc_q <= 1'b0;
      root_q   <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SQRT_SEQ_REM_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rad_q    <= rad_d;
      prem_q   <= prem_d;
      proot_q  <= proot_d;
      negAcc_q <= negAcc_d;
      root_q   <= root_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
`ifdef SQRT_SEQ_REM_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign root = root_q;
  assign neg  = neg_q;
`ifdef SQRT_SEQ_REM_EN
  assign remainder = rem_q;
`else
  assign remainder = '0;
`endif

endmodule

// File: tb/tb_sqrt_seq.sv
// ---------------------------------------------------------------------------
// tb_sqrt_seq
// Scoreboard bench for sqrt_seq with width = 8 (N = 4). Stimulus pushes the
// expected result when a request is issued, and a monitor pops and compares
// on every done pulse. Expected remainders are zero when SQRT_SEQ_REM_EN
// is not defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sqrt_seq;

  localparam int W = 8;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic         tc = 1'b0;
  logic         busy;
  logic         done;
  logic [N-1:0] root;
  logic [N:0]   remainder;
  logic         neg;

  typedef struct {
    int   root;
    int   rem;
    logic neg;
  } exp_t;

  exp_t sb[$];
  int   nCompared = 0;
  int   nMismatched = 0;

  sqrt_seq #(.width(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .tc        (tc),
    .busy      (busy),
    .done      (done),
    .root      (root),
    .remainder (remainder),
    .neg       (neg)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  function automatic void checkOutput(input string name, input int actual, input int required);
    nCompared++;
    if (actual != required) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endfunction

  // Queues an expected result in issue order.
  task automatic expectResult(input int r, input int rem, input logic n);
    exp_t e;
    e.root = r;
`ifdef SQRT_SEQ_REM_EN
    e.rem  = rem;
`else
    e.rem  = 0 * rem;
`endif
    e.neg  = n;
    sb.push_back(e);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpectedDone", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("root", int'(root), e.root);
        checkOutput("remainder", int'(remainder), e.rem);
        checkOutput("neg", int'(neg), int'(e.neg));
      end
    end
  end

  // Waits (bounded) for the unit to be idle, then presents one request.
  task automatic applyStimulus(input logic [W-1:0] av, input logic tcv);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (busy) checkOutput("idleTimeout", 1, 0);
    start = 1'b1;
    a     = av;
    tc    = tcv;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busyAfterAccept", int'(busy), 1);
  endtask

  // Counts rising edges until done is seen; -1 if it never arrives.
  task automatic waitDone(output int cycles);
    cycles = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) break;
    end
    if (!done) cycles = -1;
  endtask

  // Waits (bounded) for all queued expectations to be consumed.
  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || busy) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    checkOutput("queueDrained", sb.size(), 0);
  endtask

  initial begin
    int c;
    int mag;
    int r;
    int guard;

    // Reset state
    rst_n = 1'b0;
    #12;
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstDone", int'(done), 0);
    checkOutput("rstRoot", int'(root), 0);
    checkOutput("rstRem", int'(remainder), 0);
    checkOutput("rstNeg", int'(neg), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Perfect square and latency
    applyStimulus(8'd144, 1'b0);
    expectResult(12, 0, 1'b0);
    waitDone(c);
    checkOutput("latency144", c, 4);
    drain();

    // Directed values
    applyStimulus(8'd255, 1'b0); expectResult(15, 30, 1'b0);
    applyStimulus(8'd0,   1'b0); expectResult(0, 0, 1'b0);
    applyStimulus(8'h80,  1'b1); expectResult(11, 7, 1'b1);
    applyStimulus(8'h80,  1'b0); expectResult(11, 7, 1'b0);
    applyStimulus(8'hFF,  1'b1); expectResult(1, 0, 1'b1);
    applyStimulus(8'hF0,  1'b1); expectResult(4, 0, 1'b1);
    drain();

    // start while busy is ignored
    applyStimulus(8'd100, 1'b0);
    expectResult(10, 0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    a     = 8'd9;
    tc    = 1'b0;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!done && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("doneSeen100", int'(done), 1);

    // start in the done cycle is accepted
    start = 1'b1;
    a     = 8'd9;
    expectResult(3, 0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busyOnDoneStart", int'(busy), 1);
    checkOutput("doneDrops", int'(done), 0);
    waitDone(c);
    checkOutput("latencyB2B", c, 4);
    drain();

    // Reset in the middle of a computation
    applyStimulus(8'd200, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("abortBusy", int'(busy), 0);
    checkOutput("abortDone", int'(done), 0);
    checkOutput("abortRoot", int'(root), 0);
    checkOutput("abortRem", int'(remainder), 0);
    checkOutput("abortNeg", int'(neg), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    applyStimulus(8'd49, 1'b0);
    expectResult(7, 0, 1'b0);
    drain();

    // Sweep every radicand in both interpretations
    for (int t = 0; t < 2; t++) begin
      for (int v = 0; v < 256; v++) begin
        mag = (t == 1 && (v & 128) != 0) ? (256 - v) : v;
        r = 0;
        while ((r + 1) * (r + 1) <= mag) r++;
        applyStimulus(W'(v), t[0]);
        expectResult(r, mag - r * r, (t == 1 && (v & 128) != 0));
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
